// File: rtl/load_store_unit.sv
// MEM-stage load/store controller: one request at a time, word-only data memory
// access, sub-word load extraction/extension and read-modify-write for sub-word stores.
//
// state   | meaning
// IDLE    | ready for a request; latch fields and run fault check on accept
// READ    | word read strobe to memory, held while stalled
// CAPTURE | memory read data registered into the word buffer
// WRITE   | word write strobe with merged data, held while stalled
// DONE    | one-cycle response pulse
module load_store_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int ENTRY_NUM_LOG2 = 7
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    input  logic [1:0]            req_mode_i,
    input  logic                  req_unsigned_i,
    output logic                  resp_valid_o,
    output logic [31:0]           resp_rdata_o,
    output logic                  resp_fault_o,
    output logic [ADDR_WIDTH-1:0] dm_addr_o,
    output logic [31:0]           dm_wdata_o,
    output logic                  dm_read_o,
    output logic                  dm_write_o,
    input  logic [31:0]           dm_rdata_i,
    input  logic                  dm_stall_i
);

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_ILL  = 2'b10;
    localparam logic [1:0] MODE_WORD = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        WRITE,
        DONE
    } state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           word_buf_q;
    logic [1:0]            mode_q;
    logic                  write_q;
    logic                  unsigned_q;
    logic                  fault_q;

    logic                  accept;
    logic                  fault_in;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [31:0]           byte_shifted;
    logic [7:0]            byte_lane;
    logic [15:0]           half_lane;
    logic [31:0]           load_data;
    logic [31:0]           merged;

    // Reset is folded into ready so every output reads 0 while reset is held.
    assign accept = (state == IDLE) && reset_n_i && req_valid_i;

    always_comb begin
        fault_in = 1'b0;
        if (req_mode_i == MODE_ILL)
            fault_in = 1'b1;
        if ((req_mode_i == MODE_HALF) && req_addr_i[0])
            fault_in = 1'b1;
        if ((req_mode_i == MODE_WORD) && (req_addr_i[1:0] != 2'b00))
            fault_in = 1'b1;
        if (req_addr_i[ADDR_WIDTH-1:ENTRY_NUM_LOG2+2] != '0)
            fault_in = 1'b1;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            mode_q     <= MODE_BYTE;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            fault_q    <= 1'b0;
            word_buf_q <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr_q     <= req_addr_i;
                wdata_q    <= req_wdata_i;
                mode_q     <= req_mode_i;
                write_q    <= req_write_i;
                unsigned_q <= req_unsigned_i;
                fault_q    <= fault_in;
            end
            if (state == CAPTURE)
                word_buf_q <= dm_rdata_i;
        end
    end

    assign word_addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign byte_shifted = word_buf_q >> {addr_q[1:0], 3'b000};
    assign byte_lane    = byte_shifted[7:0];
    assign half_lane    = addr_q[1] ? word_buf_q[31:16] : word_buf_q[15:0];

    always_comb begin
        load_data = word_buf_q;
        case (mode_q)
            MODE_BYTE: load_data = {{24{~unsigned_q & byte_lane[7]}}, byte_lane};
            MODE_HALF: load_data = {{16{~unsigned_q & half_lane[15]}}, half_lane};
            default:   load_data = word_buf_q;
        endcase
    end

    // Little-endian lane merge of store data over the word read back from memory.
    always_comb begin
        merged = word_buf_q;
        case (mode_q)
            MODE_BYTE: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            MODE_HALF: merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default:   merged = wdata_q;
        endcase
    end

    always_comb begin
        state_next   = state;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        resp_rdata_o = '0;
        resp_fault_o = 1'b0;
        dm_addr_o    = '0;
        dm_wdata_o   = '0;
        dm_read_o    = 1'b0;
        dm_write_o   = 1'b0;
        case (state)
            IDLE: begin
                req_ready_o = reset_n_i;
                if (accept) begin
                    if (fault_in)
                        state_next = DONE;
                    else if (req_write_i && (req_mode_i == MODE_WORD))
                        state_next = WRITE;
                    else
                        state_next = READ;
                end
            end
            READ: begin
                dm_read_o = 1'b1;
                dm_addr_o = word_addr;
                if (!dm_stall_i)
                    state_next = CAPTURE;
            end
            CAPTURE: begin
                state_next = write_q ? WRITE : DONE;
            end
            WRITE: begin
                dm_write_o = 1'b1;
                dm_addr_o  = word_addr;
                dm_wdata_o = merged;
                if (!dm_stall_i)
                    state_next = DONE;
            end
            DONE: begin
                resp_valid_o = 1'b1;
                resp_fault_o = fault_q;
                if (!fault_q && !write_q)
                    resp_rdata_o = load_data;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- MEM-stage controller between the pipeline's EX/MEM register (upstream) and the word-organised data memory (downstream).
- Accepts one load/store request at a time and drives the data memory with word-aligned addresses and word-wide strobes only.
- Does byte-lane extraction with sign/zero extension for loads.
- Does read-modify-write for byte/half stores, checks alignment and range, and honours the memory's stall signal.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- ENTRY_NUM_LOG2, 7, log2 of data-memory word count; byte addresses >= 4*2^ENTRY_NUM_LOG2 are out of range.

Ports:
- clock_i  in  1  clock, all state on rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  block idle, request accepted when valid&ready.
- req_write_i  in  1  1=store, 0=load.
- req_addr_i  in  ADDR_WIDTH  byte address.
- req_wdata_i  in  32  store data (low bits used for byte/half).
- req_mode_i  in  2  00 byte, 01 half, 11 word, 10 illegal.
- req_unsigned_i  in  1  1 = zero-extend load, 0 = sign-extend.
- resp_valid_o  out  1  one-cycle completion pulse.
- resp_rdata_o  out  32  load result; 0 for stores and faults.
- resp_fault_o  out  1  valid with resp_valid_o: misaligned/illegal/out-of-range.
- dm_addr_o  out  ADDR_WIDTH  word-aligned address to data memory (bits[1:0]=0).
- dm_wdata_o  out  32  full word to write.
- dm_read_o  out  1  read strobe, mem mode always word.
- dm_write_o  out  1  write strobe.
- dm_rdata_i  in  32  memory read data, valid the cycle after an unstalled read cycle.
- dm_stall_i  in  1  memory busy; current strobe must be held.

Behaviour:
- Reset: all outputs 0, state IDLE. Reset mid-operation aborts the request; no strobe is emitted after reset and no response is produced.
- States: IDLE, READ, CAPTURE, WRITE, DONE.
- IDLE:
  - req_ready_o=1; all other outputs 0.
  - On valid&ready, latch addr, wdata, mode, write and unsigned.
  - Fault check on the latched fields; any fault -> DONE with fault=1:
    - mode 10 is illegal;
    - half requires addr[0]=0;
    - word requires addr[1:0]=00;
    - addr[ADDR_WIDTH-1:ENTRY_NUM_LOG2+2] must be 0.
  - No fault, word store -> WRITE; otherwise -> READ.
- READ: dm_read_o=1, dm_addr_o={addr[hi:2],2'b00}. Stays in READ while dm_stall_i=1; else -> CAPTURE.
- CAPTURE: register dm_rdata_i into the word buffer.
  - Load -> DONE, with result computed from the buffer: byte = bits[8*addr[1:0]+7 -: 8], half = bits[16*addr[1]+15 -: 16], word = whole.
  - Extension: req_unsigned_i=1 zero-fills, 0 replicates the top bit.
  - Sub-word store -> WRITE; merge replaces only the addressed byte/half lanes with the low bits of wdata, little-endian.
- WRITE: dm_write_o=1, dm_wdata_o=merged word (word store: wdata). Held while dm_stall_i=1; else -> DONE.
- DONE: resp_valid_o=1 for exactly one cycle, resp_rdata_o/resp_fault_o valid; -> IDLE. req_ready_o=0 in DONE (no back-to-back accept in the same cycle).
- Strobes: dm_read_o and dm_write_o never both 1. Strobe address and data are stable throughout any stall.
- Latency, cycles from the accept edge to resp_valid_o with no stall:
  - fault 1;
  - word store 2;
  - load 3;
  - byte/half store 4.
  - Each stall cycle adds 1.
- req_* inputs are ignored outside IDLE; latched copies are used.

Test Plan:
- Preload word 0x10=0x8899AABB. LB 0x11 signed -> resp_rdata 0x FFFFFFAA, dm_addr 0x10, resp 3 cycles after accept.
- Same word, LHU 0x12 -> 0x00008899; LH 0x12 -> 0xFFFF8899; LW 0x10 -> 0x8899AABB.
- SB 0x13 wdata 0x12345655 -> one read at 0x10, then write 0x5599AABB; resp at +4, fault 0. SH 0x10 wdata 0x0000CAFE -> 0x8899CAFE.
- LW 0x06, LH 0x03, mode 10 at 0x00, LW 0x200 (ENTRY_NUM_LOG2=7) -> each resp at +1 with fault=1, rdata 0, no dm strobe ever asserted.
- SW 0x20 0xDEADBEEF with dm_stall_i high 3 cycles -> dm_write_o held 4 cycles with constant addr/data, resp at +5.
- Assert reset_n_i low during SB's WRITE stall -> outputs 0 immediately, no resp. After release, req_ready_o=1 and the next LW completes normally.
